// File: rtl/toggle_gen_pkg.sv
// Shared types and limits for the multi-channel toggle generator.
package toggle_gen_pkg;

  typedef enum logic {
    MODE_FREE  = 1'b0,
    MODE_BURST = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int MAX_NCH = 16;

endpackage

// File: rtl/toggle_chan.sv
// One toggle channel: config registers, IDLE/RUN FSM, half-period counter,
// remaining-toggle counter and registered out/busy/done.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | out held at IDLE_LVL, config writes accepted, waits for start
//   ST_RUN  | cnt counts down, out inverts on cnt==0; BURST ends on last toggle
module toggle_chan
  import toggle_gen_pkg::*;
#(
  parameter int   CNT_W    = 8,
  parameter logic IDLE_LVL = 1'b0,
  parameter int   DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_pulses,
  input  logic             start,
  input  logic             stop,
  output logic             cfg_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  // toggles_left holds 2*pulses, so it needs one extra bit
  localparam int LW = CNT_W + 1;

  mode_t            mode_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] pulses_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LW-1:0]    left_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] reload_d;
  logic             start_ok_d;

  assign reload_d = half_q - CNT_W'(1);

  // A write landing in the same cycle as start wins; the start is dropped.
  assign start_ok_d = start & ~stop & ~cfg_we & (half_q != '0) &
                      ((mode_q == MODE_FREE) | (pulses_q != '0));

  assign cfg_ready = (state_q == ST_IDLE);
  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Configuration registers, written only while the channel is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_FREE;
      half_q   <= CNT_W'(DEF_HALF);
      pulses_q <= '0;
    end else if (cfg_we) begin
      mode_q   <= mode_t'(cfg_mode);
      half_q   <= cfg_half;
      pulses_q <= cfg_pulses;
    end
  end

  // Channel FSM with counters and registered outputs; stop has top priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      left_q  <= '0;
      out_q   <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        out_q   <= IDLE_LVL;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_ok_d) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              cnt_q   <= reload_d;
              left_q  <= {pulses_q, 1'b0};
            end
          end
          ST_RUN: begin
            if (cnt_q == '0) begin
              out_q <= ~out_q;
              cnt_q <= reload_d;
              if (mode_q == MODE_BURST) begin
                left_q <= left_q - LW'(1);
                if (left_q == LW'(1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/toggle_gen.sv
// Multi-channel toggle generator: NCH independent channels sharing one
// configuration port; cfg_ch selects the target and its ready flag.
module toggle_gen
  import toggle_gen_pkg::*;
#(
  parameter int   NCH      = 4,
  parameter int   CNT_W    = 8,
  parameter logic IDLE_LVL = 1'b0,
  parameter int   DEF_HALF = 1,
  localparam int  CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_pulses,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH-1:0]   out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done
);

  logic [NCH-1:0] sel;
  logic [NCH-1:0] rdy;
  logic [NCH-1:0] we;

  // An out-of-range cfg_ch selects nothing and therefore reads as not ready
  assign cfg_ready = |(sel & rdy);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign sel[i] = (cfg_ch == CH_W'(i));
    assign we[i]  = cfg_valid & sel[i] & rdy[i];

    toggle_chan #(
      .CNT_W    (CNT_W),
      .IDLE_LVL (IDLE_LVL),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (we[i]),
      .cfg_mode   (cfg_mode),
      .cfg_half   (cfg_half),
      .cfg_pulses (cfg_pulses),
      .start      (start[i]),
      .stop       (stop[i]),
      .cfg_ready  (rdy[i]),
      .out        (out[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_toggle_gen.sv
// Self-checking bench for toggle_gen (NCH=4, CNT_W=8, IDLE_LVL=0, DEF_HALF=1).
module tb_toggle_gen;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic       cfg_mode;
  logic [7:0] cfg_half;
  logic [7:0] cfg_pulses;
  logic [3:0] start;
  logic [3:0] stop;
  logic [3:0] out_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;

  typedef struct packed {
    logic [3:0] o;
    logic [3:0] b;
    logic [3:0] d;
    logic       r;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  toggle_gen dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_half   (cfg_half),
    .cfg_pulses (cfg_pulses),
    .start      (start),
    .stop       (stop),
    .out        (out_v),
    .busy       (busy_v),
    .done       (done_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(logic [3:0] o, logic [3:0] b, logic [3:0] d, logic r);
    exp_t e;
    e.o = o; e.b = b; e.d = d; e.r = r;
    return e;
  endfunction

  task automatic cfg_write(logic [1:0] ch, logic mode, logic [7:0] half, logic [7:0] pulses);
    cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_pulses = pulses;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    cfg_ch = 2'd0;
    repeat (3) tick();
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    e = sb.pop_front();
    nvec++;
    if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
      nerr++;
      $display("FAIL reset: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
               out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
    end
    rst = 1'b0;
  endtask

  task automatic test_free_half1();
    exp_t e;
    int n;
    cfg_ch = 2'd0;
    for (int j = 0; j <= 8; j++)
      if (j < 8) sb.push_back(mk((j % 2 == 1) ? 4'b0001 : 4'b0000, 4'b0001, 4'b0000, 1'b0));
      else       sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b0001;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL free_half1 j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      stop = (j == 7) ? 4'b0001 : 4'b0000;
      tick();
    end
    stop = 4'b0000;
  endtask

  task automatic test_free_half3();
    exp_t e;
    int n;
    cfg_write(2'd1, 1'b0, 8'd3, 8'd0);
    for (int j = 0; j <= 12; j++)
      if (j <= 6) sb.push_back(mk(((j / 3) % 2 == 1) ? 4'b0010 : 4'b0000, 4'b0010, 4'b0000, 1'b0));
      else        sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b0010;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL free_half3 j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      stop = (j == 6) ? 4'b0010 : 4'b0000;
      tick();
    end
    stop = 4'b0000;
  endtask

  task automatic test_burst();
    exp_t e;
    int n;
    cfg_write(2'd2, 1'b1, 8'd2, 8'd3);
    for (int j = 0; j <= 14; j++)
      if (j < 12)       sb.push_back(mk(((j / 2) % 2 == 1) ? 4'b0100 : 4'b0000, 4'b0100, 4'b0000, 1'b0));
      else if (j == 12) sb.push_back(mk(4'b0000, 4'b0000, 4'b0100, 1'b1));
      else              sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b0100;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL burst j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      tick();
    end
  endtask

  task automatic test_cfg_while_run();
    exp_t e;
    int n;
    cfg_write(2'd2, 1'b1, 8'd2, 8'd1);
    for (int j = 0; j <= 11; j++)
      if (j <= 3)       sb.push_back(mk((j >= 2) ? 4'b0100 : 4'b0000, 4'b0100, 4'b0000, 1'b0));
      else if (j == 4)  sb.push_back(mk(4'b0000, 4'b0000, 4'b0100, 1'b1));
      else if (j == 5)  sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
      else if (j <= 10) sb.push_back(mk(((j - 6) % 2 == 1) ? 4'b0100 : 4'b0000, 4'b0100, 4'b0000, 1'b0));
      else              sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b0100;
    tick();
    start = 4'b0000;
    // held write: FREE, half=1
    cfg_ch = 2'd2; cfg_mode = 1'b0; cfg_half = 8'd1; cfg_pulses = 8'd0;
    cfg_valid = 1'b1;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL cfg_while_run j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      if (j == 5) cfg_valid = 1'b0;
      start = (j == 5)  ? 4'b0100 : 4'b0000;
      stop  = (j == 10) ? 4'b0100 : 4'b0000;
      tick();
    end
    cfg_valid = 1'b0;
    start = 4'b0000;
    stop  = 4'b0000;
  endtask

  task automatic test_half_zero();
    exp_t e;
    int n;
    cfg_write(2'd3, 1'b0, 8'd0, 8'd0);
    repeat (3) sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b1000;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL half_zero j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      tick();
    end
  endtask

  task automatic test_pulses_zero();
    exp_t e;
    int n;
    cfg_write(2'd3, 1'b1, 8'd2, 8'd0);
    repeat (3) sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b1000;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL pulses_zero j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      tick();
    end
  endtask

  task automatic test_start_stop();
    exp_t e;
    int n;
    cfg_write(2'd3, 1'b0, 8'd1, 8'd0);
    repeat (3) sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b1000;
    stop  = 4'b1000;
    tick();
    start = 4'b0000;
    stop  = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL start_stop j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      tick();
    end
  endtask

  task automatic test_cfg_start_same();
    exp_t e;
    int n;
    // ch3 currently FREE half=1; a taken start would make it busy
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    sb.push_back(mk(4'b0000, 4'b1000, 4'b0000, 1'b0));
    sb.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 4'b1000, 1'b1));
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    cfg_ch = 2'd3; cfg_mode = 1'b1; cfg_half = 8'd1; cfg_pulses = 8'd1;
    cfg_valid = 1'b1;
    start = 4'b1000;
    tick();
    cfg_valid = 1'b0;
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL cfg_start_same j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      start = (j == 1) ? 4'b1000 : 4'b0000;
      tick();
    end
    start = 4'b0000;
  endtask

  task automatic test_stop_final();
    exp_t e;
    int n;
    // ch3 is BURST half=1 pulses=1: final toggle lands two edges after start
    sb.push_back(mk(4'b0000, 4'b1000, 4'b0000, 1'b0));
    sb.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1'b0));
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    cfg_ch = 2'd3;
    start = 4'b1000;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL stop_final j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      stop = (j == 1) ? 4'b1000 : 4'b0000;
      tick();
    end
    stop = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    int n;
    cfg_write(2'd3, 1'b1, 8'd3, 8'd4);
    for (int j = 0; j <= 16; j++)
      if (j <= 3)       sb.push_back(mk(((j / 3) % 2 == 1) ? 4'b1000 : 4'b0000, 4'b1000, 4'b0000, 1'b0));
      else if (j <= 5)  sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
      else if (j <= 15) sb.push_back(mk(((j - 6) % 2 == 1) ? 4'b1000 : 4'b0000, 4'b1000, 4'b0000, 1'b0));
      else              sb.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1'b1));
    start = 4'b1000;
    tick();
    start = 4'b0000;
    n = sb.size();
    for (int j = 0; j < n; j++) begin
      e = sb.pop_front();
      nvec++;
      if ({out_v, busy_v, done_v, cfg_ready} !== e) begin
        nerr++;
        $display("FAIL reset_mid_burst j=%0d: got out=%b busy=%b done=%b rdy=%b, want out=%b busy=%b done=%b rdy=%b",
                 j, out_v, busy_v, done_v, cfg_ready, e.o, e.b, e.d, e.r);
      end
      rst   = (j == 3) ? 1'b1 : 1'b0;
      start = (j == 5)  ? 4'b1000 : 4'b0000;
      stop  = (j == 15) ? 4'b1000 : 4'b0000;
      tick();
    end
    rst   = 1'b0;
    start = 4'b0000;
    stop  = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_mode = 1'b0;
    cfg_half = 8'd0; cfg_pulses = 8'd0; start = 4'b0000; stop = 4'b0000;
    test_reset();
    test_free_half1();
    test_free_half3();
    test_burst();
    test_cfg_while_run();
    test_half_zero();
    test_pulses_zero();
    test_start_stop();
    test_cfg_start_same();
    test_stop_final();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
